// File: rtl/l2_refill_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : l2_refill_responder_if
// Purpose  : L1 refill request/response bus plus the word-read port to memory.
// Revision : 1.0
// ============================================================================
interface l2_refill_responder_if #(
  parameter int data_width    = 32,
  parameter int address_width = 32,
  parameter int block_size    = 32
);
  localparam int offset_width    = $clog2(data_width*block_size/8);
  localparam int line_addr_width = address_width - offset_width;
  localparam int cache_width     = data_width*block_size;

  logic                       REQ_VALID;
  logic [line_addr_width-1:0] REQ_ADDR;
  logic [cache_width-1:0]     RESP_DATA;
  logic                       RESP_VALID;
  logic                       MEM_RD;
  logic [address_width-1:0]   MEM_ADDR;
  logic [data_width-1:0]      MEM_RDATA;
  logic                       MEM_RDATA_VALID;

  // The responder is the slave of the L1 request side and drives the memory side.
  modport slave (
    input  REQ_VALID, REQ_ADDR, MEM_RDATA, MEM_RDATA_VALID,
    output RESP_DATA, RESP_VALID, MEM_RD, MEM_ADDR
  );

  modport master (
    output REQ_VALID, REQ_ADDR, MEM_RDATA, MEM_RDATA_VALID,
    input  RESP_DATA, RESP_VALID, MEM_RD, MEM_ADDR
  );
endinterface
`default_nettype wire

// File: rtl/l2_refill_responder.sv
`default_nettype none
// ============================================================================
// Module   : l2_refill_responder
// Purpose  : Queues L1 line refills (2 deep) and assembles each line word by word.
// Revision : 1.0
// ============================================================================
module l2_refill_responder #(
  parameter int data_width    = 32,
  parameter int address_width = 32,
  parameter int block_size    = 32
) (
  input  wire                  CLK,
  input  wire                  RST,
  l2_refill_responder_if.slave bus,
  output logic                 BUSY,
  output logic                 OVERFLOW
);
  localparam int offset_width    = $clog2(data_width*block_size/8);
  localparam int line_addr_width = address_width - offset_width;
  localparam int cache_width     = data_width*block_size;
  localparam int cnt_width       = $clog2(block_size);
  localparam int byte_bits       = $clog2(data_width/8);
  localparam logic [cnt_width-1:0] last_idx = cnt_width'(block_size-1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } state_t;

  state_t state, state_next;

  logic [line_addr_width-1:0] fifo_mem [2];
  logic                       rd_ptr, wr_ptr;
  logic [1:0]                 fifo_cnt;
  logic                       fifo_empty, fifo_full;
  logic                       push, pop;

  logic [line_addr_width-1:0] cur_line;
  logic [cnt_width-1:0]       word_cnt;
  logic [cache_width-1:0]     line_buf, line_next, resp_data;
  logic                       mem_rd, resp_valid, take_word, last_word, overflow;

  assign fifo_empty = (fifo_cnt == 2'd0);
  assign fifo_full  = (fifo_cnt == 2'd2);
  assign last_word  = (word_cnt == last_idx);
  // A full FIFO still accepts when its head leaves in the same cycle.
  assign push       = bus.REQ_VALID && (!fifo_full || pop);

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    mem_rd     = 1'b0;
    resp_valid = 1'b0;
    take_word  = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        mem_rd     = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (bus.MEM_RDATA_VALID) begin
          take_word  = 1'b1;
          state_next = last_word ? RESPOND : ISSUE;
        end
      end
      RESPOND: begin
        resp_valid = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Storage only; occupancy and pointers below define which entries are live.
  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr] <= bus.REQ_ADDR;
  end

  always_comb begin
    line_next = line_buf;
    line_next[word_cnt*data_width +: data_width] = bus.MEM_RDATA;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      fifo_cnt  <= 2'd0;
      overflow  <= 1'b0;
      cur_line  <= '0;
      word_cnt  <= '0;
      line_buf  <= '0;
      resp_data <= '0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + 2'(push) - 2'(pop);
      if (bus.REQ_VALID && fifo_full && !pop) overflow <= 1'b1;
      if (pop) begin
        cur_line <= fifo_mem[rd_ptr];
        word_cnt <= '0;
      end
      // The last word goes straight to the output register so RESP_DATA
      // stays stable while the next line is being gathered in line_buf.
      if (take_word) begin
        line_buf <= line_next;
        if (last_word) resp_data <= line_next;
        else           word_cnt  <= word_cnt + cnt_width'(1);
      end
    end
  end

  assign bus.MEM_RD     = mem_rd;
  assign bus.MEM_ADDR   = {cur_line, word_cnt, {byte_bits{1'b0}}};
  assign bus.RESP_VALID = resp_valid;
  assign bus.RESP_DATA  = resp_data;
  assign BUSY           = (state != IDLE) || !fifo_empty;
  assign OVERFLOW       = overflow;
endmodule
`default_nettype wire

// File: doc/l2_refill_responder.md
L2_REFILL_RESPONDER -- requirements
Module: l2_refill_responder

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  - data_width, 32, memory word width in bits
  - address_width, 32, byte address width
  - block_size, 32, words per cache line
REQ-002 Derived values SHALL be:
  - offset_width = clog2(data_width*block_size/8), which is 7 at defaults
  - line_addr_width = address_width - offset_width
  - cache_width = data_width*block_size
  - cnt_width = clog2(block_size)
REQ-003 Ports SHALL be (name, direction, width, meaning):
  - CLK, in, 1, clock; all logic on the rising edge
  - RST, in, 1, reset; synchronous, active-high
  - REQ_VALID, in, 1, one-cycle line-refill request strobe from the L1
  - REQ_ADDR, in, line_addr_width, line address; sampled when REQ_VALID=1
  - RESP_DATA, out, cache_width, assembled line; word i at bits [i*data_width +: data_width]
  - RESP_VALID, out, 1, one-cycle pulse; RESP_DATA is valid in that cycle
  - BUSY, out, 1, high whenever a refill is in progress or the queue is non-empty
  - OVERFLOW, out, 1, sticky; set when a request is dropped
  - MEM_RD, out, 1, one-cycle word read strobe to backing memory
  - MEM_ADDR, out, address_width, byte address of the word being read
  - MEM_RDATA, in, data_width, read data
  - MEM_RDATA_VALID, in, 1, MEM_RDATA is valid this cycle

Function
REQ-004 Requests SHALL enter a 2-entry FIFO of line addresses. A push occurs when REQ_VALID=1 and the FIFO is not full, or when the FIFO is full and a pop happens in the same cycle.
REQ-005 When REQ_VALID=1, the FIFO is full and no pop occurs in that cycle, the request SHALL be dropped and OVERFLOW set to 1. OVERFLOW is cleared only by RST.
REQ-006 The FSM SHALL have states IDLE, ISSUE, WAIT and RESPOND.
REQ-007 In IDLE with the FIFO non-empty, the block SHALL pop the head into cur_line, clear word_cnt to 0, and go to ISSUE on the next cycle.
REQ-008 In ISSUE, the block SHALL assert MEM_RD for exactly one cycle with MEM_ADDR = {cur_line, word_cnt, log2(data_width/8) zero bits}, then go to WAIT.
REQ-009 In WAIT, on MEM_RDATA_VALID=1 the block SHALL write MEM_RDATA into line-buffer slot word_cnt, then:
  - if word_cnt = block_size-1, go to RESPOND
  - otherwise increment word_cnt and return to ISSUE
REQ-010 MEM_RDATA_VALID SHALL be ignored in every state other than WAIT.
REQ-011 In RESPOND, the block SHALL drive RESP_VALID=1 for exactly one cycle with the full line on RESP_DATA, then go to IDLE.
REQ-012 RESP_DATA SHALL hold its value after RESP_VALID until the next RESPOND.
REQ-013 Back-to-back refills: if the FIFO is non-empty in IDLE, the next ISSUE SHALL follow with no extra idle cycle beyond the IDLE pop cycle.
REQ-014 Responses SHALL be returned in request order; there is exactly one RESP_VALID pulse per accepted request.
REQ-015 BUSY SHALL be asserted combinationally as (state != IDLE) | fifo_not_empty.
REQ-016 Minimum latency from REQ_VALID (FIFO empty, FSM idle, memory answering 1 cycle after MEM_RD) to RESP_VALID SHALL be 2*block_size + 2 cycles.
REQ-017 word_cnt SHALL never wrap. The transition to RESPOND happens on the last word, before any increment.

Reset
REQ-018 On RST:
  - state is IDLE; FIFO is empty; word_cnt is 0
  - RESP_VALID, MEM_RD and OVERFLOW are 0; MEM_ADDR is 0; RESP_DATA is 0
REQ-019 RST asserted mid-refill SHALL abandon the refill with no RESP_VALID. Any MEM_RDATA_VALID arriving after reset is ignored.
REQ-020 A REQ_VALID in the same cycle as RST SHALL be discarded.

Verification
REQ-021 Single refill: REQ_ADDR=0x0000123, memory returns word i = 0xA5000000+i one cycle after each MEM_RD.
  -> MEM_ADDR sequence 0x00009180, 0x00009184 … 0x000091FC (32 reads)
  -> one RESP_VALID 66 cycles after REQ_VALID, RESP_DATA[31:0]=0xA5000000, RESP_DATA[1023:992]=0xA500001F
REQ-022 Three requests 0x10, 0x11, 0x12 on consecutive cycles while idle.
  -> all accepted (one popped immediately, two queued), OVERFLOW stays 0
  -> three RESP_VALID pulses in order 0x10, 0x11, 0x12
REQ-023 Fourth request while busy with the FIFO holding 2 entries.
  -> request dropped, OVERFLOW=1, exactly three responses
REQ-024 Memory stalls 5 cycles on word 7, with a spurious MEM_RDATA_VALID in ISSUE.
  -> the spurious strobe is ignored, slot 7 holds the delayed data, exactly 32 MEM_RD pulses
REQ-025 RST pulsed after word 10 of a refill, followed by a late MEM_RDATA_VALID.
  -> no RESP_VALID, BUSY=0 and OVERFLOW=0 the cycle after reset
  -> a new request 0x55 then completes normally
REQ-026 Simultaneous pop and push with the FIFO full.
  -> new request accepted, OVERFLOW stays 0
